skeeball_hole_encoder: RTL

Front end for the skeeball score accumulator. It conditions the seven raw hole sensors and emits debounced, single-cycle, one-hot score pulses (in0..in100). It also owns the game flow: the playstate level, ball count and game-over flag. It sits between the lane sensor pins and the score accumulator, and drives the accumulator's playstate and score inputs directly.

---
 rtl/skeeball_hole_encoder_if.sv | 32 +++
 rtl/skeeball_hole_encoder.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/skeeball_hole_encoder_if.sv
// Signal bundle between the lane pins / score accumulator and the hole encoder.
// The slave side is the encoder; the master side drives the raw pins and observes the outputs.
interface skeeball_hole_encoder_if;
    logic       start;
    logic       sw0;
    logic       sw10;
    logic       sw20;
    logic       sw30;
    logic       sw40;
    logic       sw50;
    logic       sw100;
    logic       playstate;
    logic       in0;
    logic       in10;
    logic       in20;
    logic       in30;
    logic       in40;
    logic       in50;
    logic       in100;
    logic [3:0] balls_left;
    logic       game_over;

    modport master (
        output start, sw0, sw10, sw20, sw30, sw40, sw50, sw100,
        input  playstate, in0, in10, in20, in30, in40, in50, in100, balls_left, game_over
    );

    modport slave (
        input  start, sw0, sw10, sw20, sw30, sw40, sw50, sw100,
        output playstate, in0, in10, in20, in30, in40, in50, in100, balls_left, game_over
    );
endinterface

// File: rtl/skeeball_hole_encoder.sv
// Skeeball lane front end: synchronizes and debounces the hole sensors and start button,
// serializes hits into one-hot score pulses, and runs the IDLE/PLAY/OVER/CLEAR game flow.
module skeeball_hole_encoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int BALLS           = 9
) (
    input  logic                         clk,
    input  logic                         reset,
    skeeball_hole_encoder_if.slave       bus
);
    localparam int NSW      = 7;
    localparam int NCH      = NSW + 1;
    localparam int START_CH = NSW;

    typedef enum logic [1:0] {IDLE, PLAY, OVER, CLEAR} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [NCH-1:0]   w_raw;
    logic [NCH-1:0]   w_rise;
    logic [NSW-1:0]   r_pend;
    logic [NSW-1:0]   w_grant;
    logic [NSW-1:0]   w_fire;
    logic [NSW-1:0]   r_in;
    logic [3:0]       r_balls;
    logic             w_play_ok;
    logic             w_start_evt;
    logic             w_playstate;
    logic             w_game_over;

    // Channel order is by score value so that the highest index wins arbitration.
    assign w_raw = {bus.start, bus.sw100, bus.sw50, bus.sw40, bus.sw30, bus.sw20, bus.sw10, bus.sw0};

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_cond
            logic       r_s1;
            logic       r_s2;
            logic       r_db;
            logic [7:0] r_cnt;
            logic       w_expire;

            assign w_expire   = (r_s2 != r_db) && (r_cnt == 8'(DEBOUNCE_CYCLES - 1));
            assign w_rise[gi] = w_expire && r_s2;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_s1  <= 1'b0;
                    r_s2  <= 1'b0;
                    r_db  <= 1'b0;
                    r_cnt <= 8'd0;
                end else begin
                    r_s1 <= w_raw[gi];
                    r_s2 <= r_s1;
                    if (r_s2 == r_db) begin
                        r_cnt <= 8'd0;
                    end else if (w_expire) begin
                        r_db  <= r_s2;
                        r_cnt <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
            end
        end
    endgenerate

    assign w_start_evt = w_rise[START_CH];

    always_comb begin
        w_grant = '0;
        for (int i = 0; i < NSW; i++) begin
            if (r_pend[i]) begin
                w_grant    = '0;
                w_grant[i] = 1'b1;
            end
        end
    end

    // Once the last ball is scored no further pulse may issue before OVER takes effect.
    assign w_play_ok = (r_state == PLAY) && (r_balls != 4'd0);
    assign w_fire    = w_play_ok ? w_grant : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_playstate  = 1'b0;
        w_game_over  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_evt) w_state_next = PLAY;
            end
            PLAY: begin
                w_playstate = 1'b1;
                if (r_balls == 4'd0) w_state_next = OVER;
            end
            OVER: begin
                w_playstate = 1'b1;
                w_game_over = 1'b1;
                if (w_start_evt) w_state_next = CLEAR;
            end
            CLEAR: begin
                w_state_next = PLAY;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend  <= '0;
            r_in    <= '0;
            r_balls <= 4'd0;
        end else begin
            r_pend <= w_play_ok ? ((r_pend & ~w_grant) | w_rise[NSW-1:0]) : '0;
            r_in   <= w_fire;
            if (r_state != PLAY && w_state_next == PLAY) begin
                r_balls <= 4'(BALLS);
            end else if (|w_fire) begin
                r_balls <= r_balls - 4'd1;
            end
        end
    end

    assign bus.playstate  = w_playstate;
    assign bus.game_over  = w_game_over;
    assign bus.balls_left = r_balls;
    assign bus.in0        = r_in[0];
    assign bus.in10       = r_in[1];
    assign bus.in20       = r_in[2];
    assign bus.in30       = r_in[3];
    assign bus.in40       = r_in[4];
    assign bus.in50       = r_in[5];
    assign bus.in100      = r_in[6];
endmodule
